// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM state type and byte-merge helper shared by dmem_cache and dcache_array
package dcache_pkg;
  localparam int ADDR_W = 12;
  localparam int LINES = 8;
  localparam int WORDS_PER_LINE = 4;
  localparam int MEM_LAT = 1;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int PH_W = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage with byte-enable word write, line-valid set and async lookup
module dcache_array
  import dcache_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES][WORDS_PER_LINE];
  // valid bits clear on reset and are set only when a line's fill completes
  always_ff @(posedge CLK)
    if (!RSTn) valid <= '0;
    else if (set_en) valid[wr_idx] <= 1'b1;
  // tags and words need no reset since valid gates their use
  always_ff @(posedge CLK) begin
    if (set_en) tags[wr_idx] <= set_tag;
    if (wr_en) data[wr_idx][wr_off] <= be_merge(data[wr_idx][wr_off], wr_data, wr_be);
  end
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_word = data[rd_idx][rd_off];
endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through L1 D-cache; define DCACHE_WRITE_ALLOC_EN for write-allocate
module dmem_cache
  import dcache_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Cache_CSN,
  input  logic              Cache_WEN,
  input  logic [3:0]        Cache_BE,
  input  logic [ADDR_W-1:0] Cache_ADDR,
  input  logic [31:0]       Cache_DI,
  output logic [31:0]       Cache_DOUT,
  output logic              RDY,
  output logic              VALID,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [3:0]        D_MEM_BE,
  output logic [ADDR_W-1:0] D_MEM_ADDR,
  output logic [31:0]       D_MEM_DOUT,
  input  logic [31:0]       D_MEM_DI
);
`ifdef DCACHE_WRITE_ALLOC_EN
  localparam bit WALLOC = 1'b1;
`else
  localparam bit WALLOC = 1'b0;
`endif
  state_t state, nxt;
  logic [ADDR_W-1:0] req_addr, lk_addr;
  logic req_rd;
  logic [3:0] req_be;
  logic [31:0] req_di;
  logic [OFF_W-1:0] cnt;
  logic [PH_W-1:0] ph;
  logic rd_valid, hit, accept, cap, last;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0] rd_word;
  assign lk_addr = state == IDLE ? Cache_ADDR : req_addr;
  assign hit = rd_valid && rd_tag == lk_addr[ADDR_W-1 -: TAG_W];
  assign accept = state == IDLE && RDY && !Cache_CSN;
  assign cap = state == FILL && ph == PH_W'(MEM_LAT);
  assign last = cap && cnt == OFF_W'(WORDS_PER_LINE - 1);
  assign VALID = state == RESP;
  dcache_array u_array (
    .CLK(CLK),
    .RSTn(RSTn),
    .rd_idx(lk_addr[OFF_W +: IDX_W]),
    .rd_off(lk_addr[OFF_W-1:0]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_word(rd_word),
    .wr_en(cap || (state == WRITE && hit)),
    .wr_idx(req_addr[OFF_W +: IDX_W]),
    .wr_off(cap ? cnt : req_addr[OFF_W-1:0]),
    .wr_be(cap ? 4'hF : req_be),
    .wr_data(cap ? D_MEM_DI : req_di),
    .set_en(last),
    .set_tag(req_addr[ADDR_W-1 -: TAG_W])
  );
  // next state and D_MEM drive; memory pins sit idle outside fill address cycles and the write cycle
  always_comb begin
    nxt = state;
    D_MEM_CSN = 1'b1;
    D_MEM_WEN = 1'b1;
    D_MEM_BE = '0;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;
    case (state)
      IDLE: nxt = !accept ? IDLE : !hit && (Cache_WEN || WALLOC) ? FILL : Cache_WEN ? RESP : WRITE;
      FILL: begin
        nxt = !last ? FILL : req_rd ? RESP : WRITE;
        if (ph == '0) begin
          D_MEM_CSN = 1'b0;
          D_MEM_BE = 4'hF;
          D_MEM_ADDR = {req_addr[ADDR_W-1:OFF_W], cnt};
        end
      end
      WRITE: begin
        nxt = RESP;
        D_MEM_CSN = 1'b0;
        D_MEM_WEN = 1'b0;
        D_MEM_BE = req_be;
        D_MEM_ADDR = req_addr;
        D_MEM_DOUT = req_di;
      end
      default: nxt = IDLE;
    endcase
  end
  // state, request latch, fill counters and read-data register
  always_ff @(posedge CLK)
    if (!RSTn) begin
      state <= IDLE;
      RDY <= 1'b0;
      Cache_DOUT <= '0;
      req_addr <= '0;
      req_rd <= 1'b1;
      req_be <= '0;
      req_di <= '0;
      cnt <= '0;
      ph <= '0;
    end else begin
      state <= nxt;
      RDY <= nxt == IDLE;
      if (accept) begin
        req_addr <= Cache_ADDR;
        req_rd <= Cache_WEN;
        req_be <= Cache_BE;
        req_di <= Cache_DI;
        cnt <= '0;
        ph <= '0;
      end
      if (accept && Cache_WEN && hit) Cache_DOUT <= rd_word;
      if (state == FILL) begin
        ph <= cap ? '0 : ph + 1'b1;
        if (cap) cnt <= cnt + 1'b1;
        if (cap && req_rd && cnt == req_addr[OFF_W-1:0]) Cache_DOUT <= D_MEM_DI;
      end
    end
endmodule
